// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use hazard detection and stall counter
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_regRData1,
    input  logic [XLEN-1:0]   id_regRData2,
    input  logic              id_regWrite,
    input  logic              id_memRead,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        wb_rd,
    input  logic              wb_rw,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    input  logic              ex_stall,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [4:0]        id_ex_rs1,
    output logic [4:0]        id_ex_rs2,
    output logic [4:0]        id_ex_rd,
    output logic [XLEN-1:0]   id_ex_data_regRData1,
    output logic [XLEN-1:0]   id_ex_data_regRData2,
    output logic              id_ex_regWrite,
    output logic              id_ex_memRead,
    output logic [CTRL_W-1:0] id_ex_ctrl,
    output logic              stall_if_id,
    output logic [CNT_W-1:0]  stall_cycles
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
    logic              reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              hazard;
    logic              stall;

    // A WB write landing this cycle overrides stale register-file data; x0 is never patched.
    function automatic logic [XLEN-1:0] wb_patch(input logic [4:0] rs, input logic [XLEN-1:0] data,
                                                 input logic rw, input logic [4:0] rd,
                                                 input logic [XLEN-1:0] wdata);
        return (rw && rd != 5'd0 && rd == rs) ? wdata : data;
    endfunction

    always_comb begin
        hazard = id_valid && valid_q && mem_read_q && (rd_q != 5'd0) &&
                 ((id_uses_rs1 && id_rs1 == rd_q) || (id_uses_rs2 && id_rs2 == rd_q));
        stall  = rst_n && (ex_stall || (hazard && !ex_flush));

        valid_d     = valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        op1_d       = wb_patch(rs1_q, op1_q, wb_rw, wb_rd, wb_data);
        op2_d       = wb_patch(rs2_q, op2_q, wb_rw, wb_rd, wb_data);
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        ctrl_d      = ctrl_q;

        if (ex_flush || (!ex_stall && hazard)) begin
            valid_d     = 1'b0;
            pc_d        = '0;
            imm_d       = '0;
            rs1_d       = '0;
            rs2_d       = '0;
            rd_d        = '0;
            op1_d       = '0;
            op2_d       = '0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ctrl_d      = '0;
        end else if (!ex_stall) begin
            valid_d     = id_valid;
            pc_d        = id_pc;
            imm_d       = id_imm;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            op1_d       = wb_patch(id_rs1, id_regRData1, wb_rw, wb_rd, wb_data);
            op2_d       = wb_patch(id_rs2, id_regRData2, wb_rw, wb_rd, wb_data);
            reg_write_d = id_regWrite && id_valid;
            mem_read_d  = id_memRead && id_valid;
            ctrl_d      = id_ctrl;
        end

        stall_cnt_d = (stall && stall_cnt_q != {CNT_W{1'b1}}) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_ex_valid          = valid_q;
    assign id_ex_pc             = pc_q;
    assign id_ex_imm            = imm_q;
    assign id_ex_rs1            = rs1_q;
    assign id_ex_rs2            = rs2_q;
    assign id_ex_rd             = rd_q;
    assign id_ex_data_regRData1 = op1_q;
    assign id_ex_data_regRData2 = op2_q;
    assign id_ex_regWrite       = reg_write_q;
    assign id_ex_memRead        = mem_read_q;
    assign id_ex_ctrl           = ctrl_q;
    assign stall_if_id          = stall;
    assign stall_cycles         = stall_cnt_q;

endmodule
